// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback stage: counter CSR addresses,
// the CLEAR/RUN state encoding and the retire-trace record layout.
package wb_pkg;

  localparam logic [11:0] MCYCLE    = 12'hB00;
  localparam logic [11:0] MCYCLEH   = 12'hB80;
  localparam logic [11:0] MINSTRET  = 12'hB02;
  localparam logic [11:0] MINSTRETH = 12'hB82;
  localparam logic [11:0] CYCLE     = 12'hC00;
  localparam logic [11:0] CYCLEH    = 12'hC80;
  localparam logic [11:0] INSTRET   = 12'hC02;
  localparam logic [11:0] INSTRETH  = 12'hC82;

  localparam logic [5:0] REG_X0 = 6'd0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_e;

  // 32 + 32 + 6 + 32 + 1 = 103 bits, PC in the most significant bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  rd_id;
    logic [31:0] wb_data;
    logic        wb_enable;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic valid/ready FIFO with a saturating drop counter. A push arriving
// while full is lost unless a pop frees the slot in the same cycle.
module wb_trace_fifo #(
  parameter int W     = 103,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic [15:0]  drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic [15:0]   r_drop;

  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign valid_o   = (r_cnt != '0);
  assign w_pop     = valid_o & ready_i;
  assign w_push_ok = push_i & (~w_full | w_pop);
  assign w_drop    = push_i & w_full & ~w_pop;
  assign data_o    = r_mem[r_rd_ptr];
  assign drop_o    = r_drop;

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: 64-entry regfile with post-reset clear sweep, bypassed read
// ports, mcycle/minstret counters. Optional retire trace under WB_TRACE_EN.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int NREGS       = 64,
  parameter int REGID_W     = 6,
  parameter int TRACE_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [31:0]        MW_PC_i,
  input  logic [31:0]        MW_instr_i,
  input  logic               MW_nop_i,
  input  logic [REGID_W-1:0] MW_rdId_i,
  input  logic [31:0]        MW_wbData_i,
  input  logic               MW_wbEnable_i,
  input  logic [REGID_W-1:0] rs1Id_i,
  input  logic [REGID_W-1:0] rs2Id_i,
  input  logic [REGID_W-1:0] rs3Id_i,
  output logic [31:0]        rs1Data_o,
  output logic [31:0]        rs2Data_o,
  output logic [31:0]        rs3Data_o,
  output logic               busy_o,
  input  logic               csrWEn_i,
  input  logic [11:0]        csrWAddr_i,
  input  logic [31:0]        csrWData_i,
  input  logic [11:0]        csrRAddr_i,
  output logic [31:0]        csrRData_o,
  output logic               csrRHit_o,
`ifdef WB_TRACE_EN
  output logic               trace_valid_o,
  input  logic               trace_ready_i,
  output logic [102:0]       trace_data_o,
  output logic [15:0]        traceDrop_o,
`endif
  output wb_state_e          dbg_state_o
);

  wb_state_e          r_state;
  wb_state_e          w_state_nxt;
  logic [REGID_W-1:0] r_clr_idx;
  logic [REGID_W-1:0] w_clr_idx_nxt;
  logic [31:0]        r_regs [NREGS];
  logic [63:0]        r_mcycle;
  logic [63:0]        r_minstret;

  logic w_run;
  logic w_commit;
  logic w_retire;

  assign w_run       = (r_state == RUN);
  assign w_commit    = w_run & MW_wbEnable_i & ~MW_nop_i & (MW_rdId_i != REG_X0);
  assign w_retire    = w_run & ~MW_nop_i;
  assign busy_o      = (r_state == CLEAR);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == REGID_W'(NREGS - 1)) w_state_nxt = RUN;
      end
      RUN: w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // The sweep owns the write port while clearing; pipeline commits only in RUN.
  always_ff @(posedge clk_i) begin
    if (r_state == CLEAR) r_regs[r_clr_idx] <= '0;
    else if (w_commit)    r_regs[MW_rdId_i] <= MW_wbData_i;
  end

  function automatic logic [31:0] read_port(input logic [REGID_W-1:0] id);
    logic [31:0] v;
    v = r_regs[id];
    if (!w_run || (id == REG_X0))         v = '0;
    else if (w_commit && (id == MW_rdId_i)) v = MW_wbData_i;
    return v;
  endfunction

  assign rs1Data_o = read_port(rs1Id_i);
  assign rs2Data_o = read_port(rs2Id_i);
  assign rs3Data_o = read_port(rs3Id_i);

  logic w_wr_mcy_lo, w_wr_mcy_hi, w_wr_ins_lo, w_wr_ins_hi;
  assign w_wr_mcy_lo = csrWEn_i & (csrWAddr_i == MCYCLE);
  assign w_wr_mcy_hi = csrWEn_i & (csrWAddr_i == MCYCLEH);
  assign w_wr_ins_lo = csrWEn_i & (csrWAddr_i == MINSTRET);
  assign w_wr_ins_hi = csrWEn_i & (csrWAddr_i == MINSTRETH);

  // A CSR write replaces the increment; the untouched half gets no carry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_wr_mcy_lo)      r_mcycle <= {r_mcycle[63:32], csrWData_i};
      else if (w_wr_mcy_hi) r_mcycle <= {csrWData_i, r_mcycle[31:0]};
      else if (w_run)       r_mcycle <= r_mcycle + 64'd1;

      if (w_wr_ins_lo)      r_minstret <= {r_minstret[63:32], csrWData_i};
      else if (w_wr_ins_hi) r_minstret <= {csrWData_i, r_minstret[31:0]};
      else if (w_retire)    r_minstret <= r_minstret + 64'd1;
    end
  end

  always_comb begin
    csrRHit_o  = 1'b1;
    csrRData_o = '0;
    case (csrRAddr_i)
      MCYCLE,    CYCLE:    csrRData_o = r_mcycle[31:0];
      MCYCLEH,   CYCLEH:   csrRData_o = r_mcycle[63:32];
      MINSTRET,  INSTRET:  csrRData_o = r_minstret[31:0];
      MINSTRETH, INSTRETH: csrRData_o = r_minstret[63:32];
      default:             csrRHit_o  = 1'b0;
    endcase
  end

`ifdef WB_TRACE_EN
  trace_entry_t w_trace_in;
  assign w_trace_in = '{pc: MW_PC_i, instr: MW_instr_i, rd_id: MW_rdId_i,
                        wb_data: MW_wbData_i, wb_enable: MW_wbEnable_i};

  wb_trace_fifo #(
    .W     ($bits(trace_entry_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_retire),
    .data_i  (w_trace_in),
    .valid_o (trace_valid_o),
    .ready_i (trace_ready_i),
    .data_o  (trace_data_o),
    .drop_o  (traceDrop_o)
  );
`else
  logic w_unused_trace;
  assign w_unused_trace = ^{MW_PC_i, MW_instr_i};
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: stimulus pushes expected values into a
// queue, a negedge monitor pops and compares against the live DUT outputs.
`timescale 1ns/1ps
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int SEL_RS1 = 0, SEL_RS2 = 1, SEL_RS3 = 2, SEL_BUSY = 3;
  localparam int SEL_CSR = 4, SEL_HIT = 5, SEL_TVALID = 6, SEL_TPC = 7, SEL_TDROP = 8;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] MW_PC_i, MW_instr_i, MW_wbData_i;
  logic        MW_nop_i, MW_wbEnable_i;
  logic [5:0]  MW_rdId_i, rs1Id_i, rs2Id_i, rs3Id_i;
  logic [31:0] rs1Data_o, rs2Data_o, rs3Data_o;
  logic        busy_o;
  logic        csrWEn_i;
  logic [11:0] csrWAddr_i, csrRAddr_i;
  logic [31:0] csrWData_i, csrRData_o;
  logic        csrRHit_o;
  wb_state_e   dbg_state_o;
`ifdef WB_TRACE_EN
  logic         trace_valid_o, trace_ready_i;
  logic [102:0] trace_data_o;
  logic [15:0]  traceDrop_o;
`endif

  writeback_unit dut (
    .clk_i(clk), .reset_i(reset_i),
    .MW_PC_i(MW_PC_i), .MW_instr_i(MW_instr_i), .MW_nop_i(MW_nop_i),
    .MW_rdId_i(MW_rdId_i), .MW_wbData_i(MW_wbData_i), .MW_wbEnable_i(MW_wbEnable_i),
    .rs1Id_i(rs1Id_i), .rs2Id_i(rs2Id_i), .rs3Id_i(rs3Id_i),
    .rs1Data_o(rs1Data_o), .rs2Data_o(rs2Data_o), .rs3Data_o(rs3Data_o),
    .busy_o(busy_o),
    .csrWEn_i(csrWEn_i), .csrWAddr_i(csrWAddr_i), .csrWData_i(csrWData_i),
    .csrRAddr_i(csrRAddr_i), .csrRData_o(csrRData_o), .csrRHit_o(csrRHit_o),
`ifdef WB_TRACE_EN
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_data_o(trace_data_o), .traceDrop_o(traceDrop_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  task automatic exp_out(input int sel, input logic [31:0] val, input string name);
    sel_q.push_back(sel);
    exp_q.push_back(val);
    name_q.push_back(name);
  endtask

  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      int          s;
      logic [31:0] e, a;
      string       n;
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (s)
        SEL_RS1:  a = rs1Data_o;
        SEL_RS2:  a = rs2Data_o;
        SEL_RS3:  a = rs3Data_o;
        SEL_BUSY: a = {31'd0, busy_o};
        SEL_CSR:  a = csrRData_o;
        SEL_HIT:  a = {31'd0, csrRHit_o};
`ifdef WB_TRACE_EN
        SEL_TVALID: a = {31'd0, trace_valid_o};
        SEL_TPC:    a = trace_data_o[102:71];
        SEL_TDROP:  a = {16'd0, traceDrop_o};
`endif
        default:  a = 32'hXXXX_XXXX;
      endcase
      check(n, a, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    MW_nop_i = 1'b1; MW_wbEnable_i = 1'b0; csrWEn_i = 1'b0;
  endtask

  task automatic commit(input logic [5:0] rd, input logic [31:0] data, input logic en, input logic nop);
    MW_rdId_i = rd; MW_wbData_i = data; MW_wbEnable_i = en; MW_nop_i = nop;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csrWEn_i = 1'b1; csrWAddr_i = addr; csrWData_i = data;
  endtask

  task automatic do_reset;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  // Counts busy cycles after reset release; optionally pokes id5 mid-sweep.
  task automatic run_sweep(input bit poke, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (poke && n == 45) begin
        commit(6'd5, 32'h1234, 1'b1, 1'b0);
        rs1Id_i = 6'd5;
        exp_out(SEL_RS1, 32'h0, "sweep_read_zero");
      end else begin
        idle();
      end
      @(negedge clk);
      if (!busy_o) break;
      n++;
      tick();
    end
    idle();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset_i = 1'b1;
    MW_PC_i = '0; MW_instr_i = '0; MW_rdId_i = '0; MW_wbData_i = '0;
    MW_nop_i = 1'b1; MW_wbEnable_i = 1'b0;
    rs1Id_i = '0; rs2Id_i = '0; rs3Id_i = '0;
    csrWEn_i = 1'b0; csrWAddr_i = '0; csrWData_i = '0; csrRAddr_i = MCYCLE;
`ifdef WB_TRACE_EN
    trace_ready_i = 1'b1;
`endif
    tick();
    do_reset();

    // Reset values in the first sweep cycle.
    rs1Id_i = 6'd9; rs2Id_i = 6'd33; rs3Id_i = 6'd0;
    exp_out(SEL_BUSY, 32'd1, "reset_busy");
    exp_out(SEL_RS1, 32'd0, "reset_rs1");
    exp_out(SEL_RS2, 32'd0, "reset_rs2");
    exp_out(SEL_CSR, 32'd0, "reset_csr_data");
    exp_out(SEL_HIT, 32'd1, "reset_csr_hit");
    run_sweep(1'b1, n);
    check("sweep_busy_cycles", n, 32'd64);

    rs1Id_i = 6'd5;
    exp_out(SEL_RS1, 32'd0, "post_sweep_id5");
    exp_out(SEL_BUSY, 32'd0, "post_sweep_busy");
    tick();

    // Reset in the middle of the sweep restarts it from index 0.
    do_reset();
    repeat (40) tick();
    exp_out(SEL_BUSY, 32'd1, "mid_sweep_busy");
    do_reset();
    run_sweep(1'b0, n);
    check("restart_busy_cycles", n, 32'd64);

    // Commit with same-cycle bypass, then from the array.
    commit(6'd3, 32'hDEADBEEF, 1'b1, 1'b0);
    rs1Id_i = 6'd3;
    exp_out(SEL_RS1, 32'hDEADBEEF, "bypass_rd3");
    tick();
    idle();
    exp_out(SEL_RS1, 32'hDEADBEEF, "regfile_rd3");
    tick();
    commit(6'd0, 32'h0000FFFF, 1'b1, 1'b0);
    rs2Id_i = 6'd0;
    exp_out(SEL_RS2, 32'd0, "bypass_rd0");
    tick();
    idle();
    exp_out(SEL_RS2, 32'd0, "regfile_rd0");
    tick();
    commit(6'd32, 32'hCAFE0032, 1'b1, 1'b0);
    rs3Id_i = 6'd32;
    exp_out(SEL_RS3, 32'hCAFE0032, "bypass_rd32");
    tick();
    idle();
    exp_out(SEL_RS3, 32'hCAFE0032, "regfile_rd32");
    tick();
    commit(6'd4, 32'h44444444, 1'b1, 1'b1);
    rs1Id_i = 6'd4;
    exp_out(SEL_RS1, 32'd0, "nop_no_bypass");
    tick();
    idle();
    exp_out(SEL_RS1, 32'd0, "nop_no_write");
    tick();

    // mcycle carry across halves, shadow reads, shadow write ignored.
    csr_write(MCYCLEH, 32'd0); tick();
    csr_write(MCYCLE, 32'hFFFFFFFF); tick();
    idle(); csrRAddr_i = CYCLE;
    exp_out(SEL_CSR, 32'hFFFFFFFF, "mcycle_lo_written");
    tick();
    csrRAddr_i = CYCLEH;
    exp_out(SEL_CSR, 32'd1, "mcycle_carry_hi");
    tick();
    csr_write(CYCLE, 32'h55); csrRAddr_i = CYCLE;
    exp_out(SEL_CSR, 32'd1, "mcycle_lo_after_carry");
    tick();
    idle();
    exp_out(SEL_CSR, 32'd2, "shadow_write_ignored");
    csrRAddr_i = CYCLE;
    tick();
    csrRAddr_i = 12'h123;
    exp_out(SEL_HIT, 32'd0, "csr_miss_hit");
    exp_out(SEL_CSR, 32'd0, "csr_miss_data");
    tick();

    // All-ones wraps to zero.
    csr_write(MCYCLEH, 32'hFFFFFFFF); tick();
    csr_write(MCYCLE, 32'hFFFFFFFF); tick();
    idle(); csrRAddr_i = MCYCLEH;
    exp_out(SEL_CSR, 32'hFFFFFFFF, "mcycle_all_ones");
    tick();
    exp_out(SEL_CSR, 32'd0, "mcycle_wrap_hi");
    tick();

    // 10 cycles with 6 retires (nop pattern), then minstret write priority.
    csr_write(MINSTRETH, 32'd0); tick();
    csr_write(MINSTRET, 32'd0); tick();
    csr_write(MCYCLEH, 32'd0); tick();
    csr_write(MCYCLE, 32'd0); tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      logic [9:0] pattern;
      pattern = 10'b1011010110;
      commit(6'd7, 32'h70 + i, pattern[i] & i[0], ~pattern[i]);
      tick();
    end
    idle(); csrRAddr_i = MCYCLE;
    exp_out(SEL_CSR, 32'd10, "mcycle_ten");
    tick();
    csrRAddr_i = INSTRET;
    exp_out(SEL_CSR, 32'd6, "minstret_six");
    tick();
    commit(6'd7, 32'h1, 1'b0, 1'b0);
    csr_write(MINSTRET, 32'd100);
    tick();
    idle(); csrRAddr_i = MINSTRET;
    exp_out(SEL_CSR, 32'd100, "minstret_write_priority");
    tick();
    csrRAddr_i = INSTRETH;
    exp_out(SEL_CSR, 32'd0, "minstret_hi");
    tick();

`ifdef WB_TRACE_EN
    // Fill beyond depth with ready low, then drain in order.
    idle(); tick(); tick();
    trace_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      MW_PC_i = 32'h100 + 32'(4 * i);
      commit(6'd8, 32'(i), 1'b1, 1'b0);
      tick();
    end
    idle();
    exp_out(SEL_TVALID, 32'd1, "trace_valid_full");
    exp_out(SEL_TDROP, 32'd2, "trace_drop_two");
    tick();
    trace_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_out(SEL_TPC, 32'h100 + 32'(4 * i), "trace_pc_order");
      tick();
    end
    exp_out(SEL_TVALID, 32'd0, "trace_empty");
    tick();
`endif

    @(negedge clk);
    if (sel_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sel_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
